// File: rtl/dmem_pkg.sv
// Shared types, default widths and parity helper for the data memory stage.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 8;
  localparam int unsigned DMEM_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_e;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DMEM_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage for the data memory stage: one sync write port, one sync read port,
// one sync debug read port and optional clear-on-reset.
module dmem_array #(
  parameter int unsigned WORD_W         = 8,
  parameter int unsigned DBG_W          = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DBG_W-1:0]  dbg_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [DBG_W-1:0]  dbg_q;

  if (CLEAR_ON_RESET) begin : g_clear
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end else begin : g_keep
    always_ff @(posedge clk_i) begin
      if (we_i && !rst_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

  // Both read ports sample the array before any same-edge write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      dbg_q   <= '0;
    end else begin
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
      dbg_q <= mem_q[dbg_addr_i][DBG_W-1:0];
    end
  end

  assign rdata_o    = rdata_q;
  assign dbg_data_o = dbg_q;

endmodule

// File: rtl/data_mem_unit.sv
// Data memory stage: valid/ready request -> one ACCESS cycle -> held response.
// Optional per-word even parity is built when DMEM_PARITY_EN is defined.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = DMEM_DATA_W,
  parameter int unsigned ADDR_W         = DMEM_ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_access_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              req_valid,
  input  logic              req_write,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              resp_was_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
`ifdef DMEM_PARITY_EN
  input  logic              parity_inject_en,
  output logic              parity_err,
`endif
  output logic [7:0]        wr_count
);

`ifdef DMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              was_write_q;
  logic [7:0]        wr_count_q;
`ifdef DMEM_PARITY_EN
  logic              inject_q;
`endif

  logic              accept;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset wins over the ACCESS write so an interrupted write never lands.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        arr_we  = we_q && !rst;
        arr_re  = !we_q;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      was_write_q <= 1'b0;
      wr_count_q  <= '0;
`ifdef DMEM_PARITY_EN
      inject_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_q   <= mem_access_addr;
        wdata_q  <= write_data;
        we_q     <= req_write;
`ifdef DMEM_PARITY_EN
        inject_q <= parity_inject_en;
`endif
      end
      if (state_q == ACCESS) begin
        was_write_q <= we_q;
        if (we_q) begin
          wr_count_q <= wr_count_q + 8'd1;
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  assign wr_word = {even_parity(wdata_q) ^ inject_q, wdata_q};
`else
  assign wr_word = wdata_q;
`endif

  dmem_array #(
    .WORD_W        (WORD_W),
    .DBG_W         (DATA_W),
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (arr_we),
    .waddr_i   (addr_q),
    .wdata_i   (wr_word),
    .re_i      (arr_re),
    .raddr_i   (addr_q),
    .rdata_o   (rd_word),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
  );

  // The read register is not updated on writes; masking gives the 0 response.
  assign read_data      = was_write_q ? '0 : rd_word[DATA_W-1:0];
  assign resp_was_write = was_write_q;
  assign wr_count       = wr_count_q;

`ifdef DMEM_PARITY_EN
  assign parity_err = resp_valid && !was_write_q &&
                      (even_parity(rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
`endif

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- 16-entry x 8-bit data memory stage directly downstream of the data transfer unit.
- Consumes the DTU's registered access address and write data through a valid/ready request handshake.
- Performs the read or write in a dedicated access cycle and returns a response (read data or write acknowledge) through a valid/ready response handshake.
- Provides a registered debug read port so the bench can inspect memory contents without disturbing the main path.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width in bits; sets depth = 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = all memory words are zeroed during reset; 0 = contents are kept across reset.

Ports:
- clk  in  1  system clock; everything updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_access_addr  in  ADDR_W  request address (from DTU).
- write_data  in  DATA_W  request write data (from DTU).
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read.
- req_ready  out  1  unit can accept a request.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- read_data  out  DATA_W  read result; 0 for writes.
- resp_was_write  out  1  response corresponds to a write.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data, registered with 1-cycle latency.
- wr_count  out  8  count of completed writes, wraps 255 -> 0.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - req_ready=0 during the reset cycle, 1 on the first cycle after reset.
  - resp_valid=0, read_data=0, resp_was_write=0, dbg_data=0, wr_count=0.
  - If CLEAR_ON_RESET=1, all memory words are set to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture addr, wdata and req_write into internal registers, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - req_ready=0.
  - Write: mem[addr] <= wdata; wr_count increments; read_data <= 0; resp_was_write <= 1.
  - Read: read_data <= mem[addr]; resp_was_write <= 0.
  - Go to RESP.
- RESP:
  - resp_valid=1; read_data and resp_was_write are held stable.
  - If resp_ready=1, go to IDLE with resp_valid=0.
  - If resp_ready=0, stay in RESP indefinitely.
- Latency: request accepted at edge N; resp_valid high from edge N+2. Minimum throughput is one request per 3 cycles.
- Back-to-back requests: req_valid held high through ACCESS/RESP is ignored until the unit returns to IDLE.
- A read immediately after a write to the same address returns the new data; there is no hazard, because the write completes in ACCESS before the next request is accepted.
- Request inputs are sampled only at the IDLE acceptance edge; later changes do not affect the in-flight operation.
- dbg_data <= mem[dbg_addr] every cycle.
  - If the ACCESS-cycle write hits dbg_addr on the same edge, dbg_data shows the old value, then the new value one cycle later.
- Reset mid-operation (ACCESS or RESP): the operation is abandoned and the FSM returns to IDLE.
  - A write in ACCESS is discarded if reset is asserted on that edge.
  - wr_count is not incremented.
- Address range is exact; there is no out-of-range case.

Optional Feature:
- Macro DMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed on write.
  - A read recomputes parity; on mismatch, output port parity_err (1 bit) pulses high with resp_valid for the response's duration.
  - Parity bits are cleared with the data when CLEAR_ON_RESET=1.
  - Bench hook: a 1-bit input parity_inject_en flips the stored parity bit on the next write.
- When undefined:
  - Neither parity_err nor parity_inject_en exists.
  - No extra storage is built.

Decomposition:
- Package dmem_pkg holds:
  - FSM state typedef (IDLE/ACCESS/RESP).
  - Default DATA_W/ADDR_W constants.
  - parity function.
- One natural sub-module: dmem_array — the storage with one sync write port, one sync read port and one sync debug read port, plus optional reset clear.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then write 0xA5 to addr 3 with resp_ready=1:
  - req_ready drops after acceptance.
  - resp_valid at accept+2 with resp_was_write=1, read_data=0.
  - wr_count=1.
- Read addr 3 immediately after that write: read_data=0xA5, resp_was_write=0.
- Write 0x3C to addr 15, then hold resp_ready=0 for 5 cycles:
  - resp_valid stays 1 with outputs stable.
  - A new req_valid during this time is not accepted.
  - Release resp_ready: return to IDLE.
- Assert rst in ACCESS of a write of 0xFF to addr 7:
  - mem[7] stays at its prior value (0 with CLEAR_ON_RESET=1).
  - wr_count=0; FSM in IDLE.
- Perform 256 writes: wr_count wraps to 0. Then dbg_addr=15 gives dbg_data equal to the last value written to addr 15, one cycle later.
- With DMEM_PARITY_EN: write 0x01 with parity_inject_en=1, then read it back: parity_err=1 with resp_valid; a clean word gives parity_err=0.
